// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU plus iterative multiply/divide unit with HI/LO.
// Build option MDU_SIGNED_EN: when defined, mult/div operate on signed
// operands; when undefined, mult behaves as multu and div as divu and no
// sign-fix logic is built (the FIX state is still visited, latency unchanged).
//
// MDU handshake: mdstart/mdop are sampled on a rising edge only while
// mdbusy=0 (FSM idle). A mult/div start holds mdbusy high for WIDTH+1 cycles;
// mddone then pulses for exactly one cycle with mdbusy already low, so a new
// start may be presented in the mddone cycle. Starts while busy are dropped.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             overflow,
  input  logic [2:0]       mdop,
  input  logic             mdstart,
  output logic             mdbusy,
  output logic             mddone,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // ALU intermediates
  logic [WIDTH-1:0] srcbb;
  logic [WIDTH-1:0] sum;

  // MDU state: acc holds product-high / partial remainder, wrk holds
  // multiplier then product-low / dividend then quotient, opb the operand-B magnitude.
  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             mddone_q, mddone_d;
`ifdef MDU_SIGNED_EN
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
`endif

  // MDU combinational scratch
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // ALU: optional B inversion with carry-in, then logic/add/set-less-than
  always_comb begin
    srcbb = alucontrol[2] ? ~srcb : srcb;
    sum   = srca + srcbb + {{(WIDTH-1){1'b0}}, alucontrol[2]};
    case (alucontrol[1:0])
      2'b00:   aluout = srca & srcbb;
      2'b01:   aluout = srca | srcbb;
      2'b10:   aluout = sum;
      default: aluout = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
    endcase
    zero     = (aluout == '0);
    overflow = (srca[WIDTH-1] == srcbb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
  end

  // MDU next-state: start/move decode in IDLE, one radix-2 step per RUN cycle,
  // sign fix and HI/LO write on FIX exit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wrk_d     = wrk_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mddone_d  = 1'b0;
`ifdef MDU_SIGNED_EN
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
`endif
    mag_a     = '0;
    mag_b     = '0;
    mul_sum   = '0;
    div_trial = '0;
    prod      = '0;
    quo       = '0;
    rem       = '0;
    case (state_q)
      ST_IDLE: begin
        if (mdstart) begin
          case (mdop)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              mag_a = srca;
              mag_b = srcb;
`ifdef MDU_SIGNED_EN
              neg_a_d = ((mdop == OP_MULT) || (mdop == OP_DIV)) && srca[WIDTH-1];
              neg_b_d = ((mdop == OP_MULT) || (mdop == OP_DIV)) && srcb[WIDTH-1];
              if (neg_a_d) mag_a = -srca;
              if (neg_b_d) mag_b = -srcb;
`endif
              is_div_d = (mdop == OP_DIV) || (mdop == OP_DIVU);
              bzero_d  = (srcb == '0);
              acc_d    = '0;
              wrk_d    = mag_a;
              opb_d    = mag_b;
              cnt_d    = CW'(WIDTH - 1);
              state_d  = ST_RUN;
            end
            OP_MTHI: hi_d = srca;
            OP_MTLO: lo_d = srca;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (!is_div_q) begin
          // shift-add: conditionally add multiplicand, shift {acc,wrk} right
          mul_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
          acc_d   = mul_sum[WIDTH:1];
          wrk_d   = {mul_sum[0], wrk_q[WIDTH-1:1]};
        end else begin
          // restoring: keep the difference only when it does not borrow
          div_trial = {acc_q, wrk_q[WIDTH-1]} - {1'b0, opb_q};
          if (!div_trial[WIDTH]) begin
            acc_d = div_trial[WIDTH-1:0];
            wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[WIDTH-2:0], wrk_q[WIDTH-1]};
            wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
          end
        end
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_FIX: begin
        prod = {acc_q, wrk_q};
        quo  = wrk_q;
        rem  = acc_q;
`ifdef MDU_SIGNED_EN
        if (neg_a_q ^ neg_b_q) begin
          prod = -prod;
          quo  = -quo;
        end
        // remainder follows the dividend; for a zero divisor this restores srca
        if (neg_a_q) rem = -rem;
`endif
        if (is_div_q) begin
          hi_d = rem;
          lo_d = bzero_q ? '1 : quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        mddone_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MDU registers; reset aborts any op in flight and clears HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mddone_q <= 1'b0;
`ifdef MDU_SIGNED_EN
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mddone_q <= mddone_d;
`ifdef MDU_SIGNED_EN
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
`endif
    end
  end

  assign mdbusy = (state_q != ST_IDLE);
  assign mddone = mddone_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed plus randomized checks of alu_mdu (WIDTH=32) against
// an arithmetic reference model; expected HI/LO results queue in exp_q.
module tb_alu_mdu;

  localparam int W = 32;
  localparam longint SMAX = (longint'(1) <<< (W-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W-1));

  localparam logic [2:0] OP_NOP0  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_NOP7  = 3'b111;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] srca, srcb;
  logic [2:0]   alucontrol, mdop;
  logic         mdstart;
  logic [W-1:0] aluout, hi, lo;
  logic         zero, overflow, mdbusy, mddone;

  int vectors     = 0;
  int miscompares = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   model_hi, model_lo;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .srca(srca), .srcb(srcb),
    .alucontrol(alucontrol), .aluout(aluout), .zero(zero), .overflow(overflow),
    .mdop(mdop), .mdstart(mdstart), .mdbusy(mdbusy), .mddone(mddone),
    .hi(hi), .lo(lo)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ALU reference: true signed sum decides overflow, SLT is the sign of the wrapped sum
  function automatic void alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ctl,
                                  output logic [W-1:0] y, output logic z, output logic v);
    logic [W-1:0] bb, s;
    longint full;
    bb   = ctl[2] ? ~b : b;
    s    = a + bb + W'(ctl[2]);
    full = longint'($signed(a)) + longint'($signed(bb)) + longint'(ctl[2]);
    v    = (full > SMAX) || (full < SMIN);
    case (ctl[1:0])
      2'b00:   y = a & bb;
      2'b01:   y = a | bb;
      2'b10:   y = s;
      default: y = W'(s[W-1]);
    endcase
    z = (y == '0);
  endfunction

  // MDU reference: returns {hi, lo} using wide native arithmetic
  function automatic logic [2*W-1:0] mdu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb, q, r;
    logic sgn;
    sgn = 1'b0;
`ifdef MDU_SIGNED_EN
    sgn = (op == OP_MULT) || (op == OP_DIV);
`endif
    sa = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    sb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    if ((op == OP_MULT) || (op == OP_MULTU)) return sa * sb;
    if (b == '0) return {a, {W{1'b1}}};
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // drive one ALU vector and compare all three outputs
  task automatic alu_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ctl);
    logic [W-1:0] ey;
    logic ez, ev;
    srca = a; srcb = b; alucontrol = ctl;
    #1;
    alu_ref(a, b, ctl, ey, ez, ev);
    check({tag, ".aluout"}, aluout, ey);
    check({tag, ".zero"}, zero, ez);
    check({tag, ".ovf"}, overflow, ev);
  endtask

  // run one mult/div from just after a negedge; optionally present a second
  // start (iop/ia) while busy at cycle intrude_at; ends at the mddone negedge
  task automatic md_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int intrude_at, input logic [2:0] iop, input logic [W-1:0] ia);
    int n;
    logic [2*W-1:0] e;
    exp_q.push_back(mdu_ref(op, a, b));
    mdop = op; srca = a; srcb = b; mdstart = 1'b1;
    @(posedge clk); @(negedge clk);
    mdstart = 1'b0; mdop = 3'($urandom_range(0, 7)); srca = $urandom; srcb = $urandom;
    check({tag, ".busy"}, mdbusy, 1'b1);
    n = 0;
    while (mddone !== 1'b1 && n < 100) begin
      if (n == intrude_at) begin
        mdop = iop; srca = ia; mdstart = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      mdstart = 1'b0;
      n++;
    end
    e = exp_q.pop_front();
    check({tag, ".latency"}, 64'(n), 64'(W + 1));
    check({tag, ".busy_at_done"}, mdbusy, 1'b0);
    check({tag, ".hilo"}, {hi, lo}, e);
    model_hi = e[2*W-1:W];
    model_lo = e[W-1:0];
  endtask

  // mthi/mtlo/nop from idle: takes effect on the next edge, never busy or done
  task automatic md_move(input string tag, input logic [2:0] op, input logic [W-1:0] a);
    mdop = op; srca = a; mdstart = 1'b1;
    @(posedge clk); @(negedge clk);
    mdstart = 1'b0;
    if (op == OP_MTHI) model_hi = a;
    if (op == OP_MTLO) model_lo = a;
    check({tag, ".hilo"}, {hi, lo}, {model_hi, model_lo});
    check({tag, ".busy"}, mdbusy, 1'b0);
    check({tag, ".done"}, mddone, 1'b0);
    @(posedge clk); @(negedge clk);
    check({tag, ".done_next"}, mddone, 1'b0);
  endtask

  initial begin
    int pulses;
    logic [2:0] op;
    logic [W-1:0] a, b;

    // reset block
    reset = 1'b1; mdstart = 1'b0; mdop = OP_NOP0;
    srca = '0; srcb = '0; alucontrol = 3'b000;
    model_hi = '0; model_lo = '0;
    @(negedge clk); @(negedge clk);
    check("rst.hilo", {hi, lo}, '0);
    check("rst.busy", mdbusy, 1'b0);
    check("rst.done", mddone, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst.hilo", {hi, lo}, '0);

    // ALU directed
    alu_vec("alu_sub", 32'd5, 32'd7, 3'b110);
    check("alu_sub.lit", aluout, 32'hFFFF_FFFE);
    check("alu_sub.zero_lit", zero, 1'b0);
    alu_vec("alu_slt", 32'd5, 32'd7, 3'b111);
    check("alu_slt.lit", aluout, 32'd1);
    alu_vec("alu_ovf", 32'h7FFF_FFFF, 32'd1, 3'b010);
    check("alu_ovf.lit", overflow, 1'b1);
    alu_vec("alu_zero", 32'h1234_5678, 32'h1234_5678, 3'b110);
    check("alu_zero.lit", zero, 1'b1);
    alu_vec("alu_subovf", 32'h8000_0000, 32'd1, 3'b110);
    alu_vec("alu_and", 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000);
    alu_vec("alu_orn", 32'h0000_0001, 32'hFFFF_0000, 3'b101);

    // ALU random
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      alu_vec($sformatf("alu_rnd%0d", i), a, b, 3'($urandom_range(0, 7)));
    end
    @(negedge clk);

    // MDU directed
    md_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, OP_NOP0, '0);
    check("multu_max.lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    md_op("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, OP_NOP0, '0);
`ifdef MDU_SIGNED_EN
    check("div_neg7.lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    check("div_neg7.lit", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
`endif
    md_op("divu_zero", OP_DIVU, 32'h1234_5678, 32'd0, -1, OP_NOP0, '0);
    check("divu_zero.lit", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    md_op("mult_min", OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, -1, OP_NOP0, '0);
    md_op("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, OP_NOP0, '0);
    md_op("div_zero", OP_DIV, 32'h8765_4321, 32'd0, -1, OP_NOP0, '0);

    // starts while busy (RUN and FIX) are dropped
    md_op("mthi_busy", OP_MULTU, 32'h0000_1234, 32'h0000_5678, 5, OP_MTHI, 32'hAAAA_5555);
    md_op("mtlo_fix", OP_DIVU, 32'h0001_0000, 32'h0000_0007, W, OP_MTLO, 32'h5555_AAAA);
    md_op("mult_busy", OP_DIVU, 32'd100, 32'd9, 10, OP_MULTU, 32'd3);

    // moves and nops from idle
    md_move("mthi_idle", OP_MTHI, 32'hAAAA_5555);
    check("mthi_idle.lit", hi, 32'hAAAA_5555);
    md_move("mtlo_idle", OP_MTLO, 32'h0BAD_F00D);
    md_move("nop0", OP_NOP0, 32'hDEAD_BEEF);
    md_move("nop7", OP_NOP7, 32'hCAFE_F00D);

    // reset in the middle of a multu aborts it
    mdop = OP_MULTU; srca = 32'hFFFF_FFFF; srcb = 32'h0000_0003; mdstart = 1'b1;
    @(posedge clk); @(negedge clk);
    mdstart = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    #1;
    model_hi = '0; model_lo = '0;
    check("midrst.hilo", {hi, lo}, '0);
    check("midrst.busy", mdbusy, 1'b0);
    check("midrst.done", mddone, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (mddone === 1'b1) pulses++;
    end
    check("midrst.no_done", 64'(pulses), 64'd0);
    check("midrst.hilo_hold", {hi, lo}, '0);
    md_op("after_rst", OP_MULTU, 32'h0001_0001, 32'h0001_0001, -1, OP_NOP0, '0);

    // MDU random, back-to-back (each start lands in the previous mddone cycle)
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      md_op($sformatf("md_rnd%0d", i), op, a, b, -1, OP_NOP0, '0);
    end

    // single-cycle mddone pulse
    @(posedge clk); @(negedge clk);
    check("done_pulse", mddone, 1'b0);
    check("final.hilo", {hi, lo}, {model_hi, model_lo});

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
